muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide engine. It produces the full 64-bit HI/LO results that the single-cycle ALU does not: the ALU truncates the product to 32 bits and returns only the quotient.
- Sits beside the ALU in the EX stage.
- Acts as the responder on a start/busy/done handshake driven by the pipeline control, which stalls while busy.
- Owns the HI and LO architectural registers.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, width and two's-complement helpers for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic [MULDIV_WIDTH-1:0] neg_w(input logic [MULDIV_WIDTH-1:0] x);
    return ~x + MULDIV_WIDTH'(1);
  endfunction

  // INT_MIN maps onto itself, which reads correctly as the unsigned magnitude 2^(W-1).
  function automatic logic [MULDIV_WIDTH-1:0] abs_w(input logic [MULDIV_WIDTH-1:0] x);
    return x[MULDIV_WIDTH-1] ? neg_w(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider that owns HI/LO.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [W2-1:0]    sh_q, sh_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  muldiv_op_t       op_in;
  logic             is_signed_in;
  logic             is_mul_q;
  logic             last_iter;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [W2-1:0]    prod;

  assign op_in        = muldiv_op_t'(op);
  assign is_signed_in = (op_in == MULT) || (op_in == DIV);
  assign is_mul_q     = (op_q == MULT) || (op_q == MULTU);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    last_iter = 1'b0;
    prod     = '0;
    mag_a    = is_signed_in ? abs_w(a) : a;
    mag_b    = is_signed_in ? abs_w(b) : b;
    // Restoring step: bring the next dividend bit into the remainder and trial-subtract.
    div_shift = {rem_q, opa_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          opa_d   = mag_a;
          opb_d   = mag_b;
          sh_d    = W2'(mag_a);
          acc_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          qsign_d = is_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign_d = is_signed_in & a[WIDTH-1];
          if (op[1] && (b == '0)) begin
            opa_d   = a;
            dz_d    = 1'b1;
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_mul_q) begin
          acc_d = acc_q + (opb_q[0] ? sh_q : '0);
          sh_d  = sh_q << 1;
          opb_d = opb_q >> 1;
        end else if (!div_diff[WIDTH]) begin
          rem_d = div_diff[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (is_mul_q && (opb_q[WIDTH-1:1] == '0)) last_iter = 1'b1;
`endif
        if (last_iter) state_d = FIX;
      end

      FIX: begin
        if (dz_q) begin
          hi_d  = opa_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_mul_q) begin
          prod  = qsign_q ? (~acc_q + W2'(1)) : acc_q;
          hi_d  = prod[W2-1:WIDTH];
          lo_d  = prod[WIDTH-1:0];
          dbz_d = 1'b0;
        end else begin
          lo_d  = qsign_q ? neg_w(opa_q) : opa_q;
          hi_d  = rsign_q ? neg_w(rem_q) : rem_q;
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MULT;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against a 64-bit arithmetic model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; lat counts edges from the start edge to the done edge inclusive.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int lat);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic [31:0] mb;
    int hb;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    lat = 34;
    eh  = '0;
    el  = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; edz = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mb = (o == 2'b00 && y[31]) ? (32'd0 - y) : y;
      hb = 0;
      for (int i = 0; i < 32; i++) if (mb[i]) hb = i + 1;
      lat = 2 + ((hb < 1) ? 1 : hb);
    end
`endif
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] eh, el;
    logic edz;
    int lat, edges;
    bit got, busy_ok;
    model(o, x, y, eh, el, edz, lat);
    @(negedge clk); op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    edges = 1; got = 1'b0; busy_ok = 1'b1;
    while (!got && edges < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1; edges++;
      got = done;
    end
    chk({tag, "/done"}, 64'(got), 64'd1);
    chk({tag, "/latency"}, 64'(edges), 64'(lat));
    chk({tag, "/busy_run"}, 64'(busy_ok), 64'd1);
    chk({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "/hi"}, 64'(hi), 64'(eh));
    chk({tag, "/lo"}, 64'(lo), 64'(el));
    chk({tag, "/dbz"}, 64'(div_by_zero), 64'(edz));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int ndone, edges;
    bit got;
    logic [31:0] h1, l1;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/busy", 64'(busy), 64'd0);
    chk("reset/done", 64'(done), 64'd0);
    chk("reset/hi", 64'(hi), 64'd0);
    chk("reset/lo", 64'(lo), 64'd0);
    chk("reset/dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(2'b11, 32'd7, 32'd2, "divu_small");
    run_op(2'b11, 32'h1234_5678, 32'd0, "divu_zero");
    run_op(2'b01, 32'd2, 32'd3, "multu_after_dz");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'd0, "div_zero_signed");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_intmin");

    // start pulsed while RUN must be ignored
    @(negedge clk); op = 2'b01; a = 32'd5; b = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0; h1 = '0; l1 = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (ndone == 0) begin h1 = hi; l1 = lo; end
        ndone++;
      end
    end
    chk("midrun/ndone", 64'(ndone), 64'd1);
    chk("midrun/lo", 64'(l1), 64'd45);
    chk("midrun/hi", 64'(h1), 64'd0);

    // start held across done: second op launches on the edge after done
    @(negedge clk); op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; op = 2'b11; a = 32'd100; b = 32'd7;
    got = 1'b0; edges = 0;
    while (!got && edges < 200) begin
      @(posedge clk); #1; edges++; got = done;
    end
    chk("b2b/first_done", 64'(got), 64'd1);
    chk("b2b/first_lo", 64'(lo), 64'd42);
    @(posedge clk); #1; start = 1'b0;
    chk("b2b/second_busy", 64'(busy), 64'd1);
    got = 1'b0; edges = 1;
    while (!got && edges < 200) begin
      @(posedge clk); #1; edges++; got = done;
    end
    chk("b2b/second_latency", 64'(edges), 64'd34);
    chk("b2b/second_lo", 64'(lo), 64'd14);
    chk("b2b/second_hi", 64'(hi), 64'd2);

    // reset mid-RUN aborts without a done
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_reset");
    @(negedge clk); op = 2'b11; a = 32'hDEAD_BEEF; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort/busy", 64'(busy), 64'd0);
    chk("abort/hi", 64'(hi), 64'd0);
    chk("abort/lo", 64'(lo), 64'd0);
    chk("abort/done", 64'(done), 64'd0);
    @(negedge clk); reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort/no_done", 64'(ndone), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
